i2c_sensor_target: RTL
======================

I2C_SENSOR_TARGET -- requirements
Module: i2c_sensor_target

Interface
REQ-001 SHALL have parameter ADDR, default 7'b1001000, the 7-bit I2C target address this block answers to.
REQ-002 SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port scl, input, 1, I2C clock from the bus initiator; this block never stretches it.
REQ-005 SHALL have port sda, inout, 1, open-drain I2C data; the block drives only 1'b0 or 1'bz, never 1'b1.
REQ-006 SHALL have port sample, input, 16, the measurement value returned on reads, MSB first.
REQ-007 SHALL have port sample_taken, output, 1, a one-clk pulse when sample is latched for a read.
REQ-008 SHALL have port wr_data, output, 16, the last complete 16-bit word written by the initiator.
REQ-009 SHALL have port wr_valid, output, 1, a one-clk pulse when wr_data updates.
REQ-010 SHALL have port busy, output, 1, high from an addressed-match ACK until STOP or START.

Function
REQ-011 SHALL pass scl and sda through 2-flop synchronizers; all edge and condition detection uses the synchronized values.
REQ-012 SHALL detect START as sync-sda falling while sync-scl is high, and STOP as sync-sda rising while sync-scl is high.
REQ-013 SHALL implement states IDLE, ADDR, ADDR_ACK, RD_BYTE, RD_ACK, WR_BYTE, WR_ACK, IGNORE.
REQ-014 SHALL enter ADDR with bit counter 0 on any START (including repeated START) from any state, releasing sda.
REQ-015 SHALL enter IDLE and release sda on STOP from any state.
REQ-016 ADDR: SHALL shift 8 bits on scl rising edges; after the 8th bit it SHALL go to ADDR_ACK if bits[7:1]==ADDR, else to IGNORE.
REQ-017 ADDR_ACK: SHALL drive sda low from the scl falling edge after bit 8 until the next scl falling edge (9th clock).
REQ-018 ADDR_ACK with R/W=1: SHALL latch sample into the TX shift register and pulse sample_taken at the first of those scl falling edges, then go to RD_BYTE with byte index 0.
REQ-019 RD_BYTE: SHALL present each bit on sda (low for 0, z for 1) at the scl falling edge, MSB first, byte 0 = sample[15:8], byte 1 = sample[7:0].
REQ-020 RD_ACK: SHALL release sda and sample the initiator ack on scl rising; on ACK go to RD_BYTE with the next byte, on NACK go to IGNORE.
REQ-021 After byte 1 is ACKed, the byte index SHALL wrap to 0 and retransmit the same latched word; no new latch occurs.
REQ-022 ADDR_ACK with R/W=0: SHALL go to WR_BYTE with byte index 0.
REQ-023 WR_BYTE: SHALL shift 8 bits on scl rising; byte 0 is stored as the high byte, byte 1 as the low byte.
REQ-024 WR_ACK: SHALL ACK every write byte, driving sda low exactly as in REQ-017.
REQ-025 After byte 1 is ACKed, SHALL update wr_data, pulse wr_valid once, and wrap the byte index to 0.
REQ-026 A lone high byte followed by STOP SHALL NOT update wr_data.
REQ-027 IGNORE: SHALL keep sda released and wait for START or STOP.
REQ-028 busy SHALL be high in ADDR_ACK, RD_*, and WR_* states for a matched address only.
REQ-029 Correct operation SHALL be guaranteed for clk >= 20x the scl frequency.

Reset
REQ-030 On rst, the block SHALL go to IDLE, release sda (z) asynchronously, clear wr_data to 16'h0000, drive sample_taken/wr_valid/busy to 0, clear counters, and set the synchronizers to 1.
REQ-031 Reset mid-transfer SHALL release sda immediately; the block SHALL ignore the bus until the next START.

Verification
REQ-032 With ADDR=0x48 and sample=16'h1A80, read 0x91 then ACK, NACK: the initiator SHALL see address ACK, bytes 0x1A and 0x80, one sample_taken pulse, and busy falling at STOP.
REQ-033 Address 0x49 read: sda SHALL stay z for the whole transaction, with no sample_taken and busy=0.
REQ-034 Write 0x90, 0xC4, 0x10, STOP: all three ACKs SHALL be given, wr_data=16'hC410, and wr_valid SHALL pulse once.
REQ-035 Change sample 16'h1A80 -> 16'h0000 after the address ACK, read 4 bytes with ACKs: the bytes SHALL be 1A,80,1A,80 (wrap, latched value held).
REQ-036 Repeated START mid-read to 0x91: a new latch and pulse SHALL occur and the transfer SHALL restart at the MSB byte.
REQ-037 Assert rst during a RD_BYTE bit with sda driven low: sda SHALL go z within the same clk, and the next valid transaction SHALL succeed.

Source files
------------

// File: rtl/i2c_sensor_target.sv
// I2C target returning a 16-bit sample on reads and collecting 16-bit words on writes.
// Latency: ~3 clk from a bus edge to the response (2-flop sync + edge register).
// Backpressure: none; scl is never stretched, every write byte is ACKed.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   scl, sda        I2C bus (sda open-drain: driven 0 or released)
//   sample          16-bit value returned on reads, MSB byte first
//   sample_taken    1-clk pulse when sample is latched for a read
//   wr_data         last complete 16-bit word written by the initiator
//   wr_valid        1-clk pulse when wr_data updates
//   busy            high while engaged in a matched transfer
module i2c_sensor_target #(
    parameter logic [6:0] ADDR = 7'b1001000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl,
    inout  wire         sda,
    input  logic [15:0] sample,
    output logic        sample_taken,
    output logic [15:0] wr_data,
    output logic        wr_valid,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_RD_BYTE, S_RD_ACK, S_WR_BYTE, S_WR_ACK, S_IGNORE
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_scl_s1, r_scl_s2, r_scl_d;
    logic        r_sda_s1, r_sda_s2, r_sda_d;
    logic [7:0]  r_shift;
    logic [3:0]  r_bit_cnt;
    logic        r_byte_idx;
    logic        r_rw;
    logic        r_ack_phase;   // 0: waiting for fall after bit 8, 1: ACK being driven
    logic [15:0] r_tx;
    logic [7:0]  r_wr_hi;
    logic [15:0] r_wr_data;
    logic        r_wr_valid;
    logic        r_sample_taken;
    logic        r_sda_low;
    logic        r_nacked;      // read ended by NACK; stay busy until STOP/START

    logic        w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [7:0]  w_shift_next;
    logic [7:0]  w_tx_byte;
    logic [2:0]  w_bit_sel;

    // Synchronizers plus one delay stage for edge detection; idle bus level is 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scl_s1 <= 1'b1; r_scl_s2 <= 1'b1; r_scl_d <= 1'b1;
            r_sda_s1 <= 1'b1; r_sda_s2 <= 1'b1; r_sda_d <= 1'b1;
        end else begin
            r_scl_s1 <= scl;      r_scl_s2 <= r_scl_s1; r_scl_d <= r_scl_s2;
            r_sda_s1 <= sda;      r_sda_s2 <= r_sda_s1; r_sda_d <= r_sda_s2;
        end
    end

    assign w_scl_rise   = r_scl_s2 & ~r_scl_d;
    assign w_scl_fall   = ~r_scl_s2 & r_scl_d;
    assign w_start      = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
    assign w_stop       = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
    assign w_shift_next = {r_shift[6:0], r_sda_s2};
    assign w_tx_byte    = r_byte_idx ? r_tx[7:0] : r_tx[15:8];
    assign w_bit_sel    = 3'd7 - r_bit_cnt[2:0];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        if (w_stop) begin
            w_next = S_IDLE;
        end else if (w_start) begin
            w_next = S_ADDR;
        end else begin
            case (r_state)
                S_ADDR:     if (w_scl_rise && r_bit_cnt == 4'd7)
                                w_next = (w_shift_next[7:1] == ADDR) ? S_ADDR_ACK : S_IGNORE;
                S_ADDR_ACK: if (w_scl_fall && r_ack_phase)
                                w_next = r_rw ? S_RD_BYTE : S_WR_BYTE;
                S_RD_BYTE:  if (w_scl_fall && r_bit_cnt == 4'd8) w_next = S_RD_ACK;
                S_RD_ACK:   if (w_scl_rise) w_next = r_sda_s2 ? S_IGNORE : S_RD_BYTE;
                S_WR_BYTE:  if (w_scl_rise && r_bit_cnt == 4'd7) w_next = S_WR_ACK;
                S_WR_ACK:   if (w_scl_fall && r_ack_phase) w_next = S_WR_BYTE;
                default:    w_next = r_state;
            endcase
        end
    end

    // Datapath: shift registers, counters, sda drive and pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift        <= 8'h00;
            r_bit_cnt      <= 4'd0;
            r_byte_idx     <= 1'b0;
            r_rw           <= 1'b0;
            r_ack_phase    <= 1'b0;
            r_tx           <= 16'h0000;
            r_wr_hi        <= 8'h00;
            r_wr_data      <= 16'h0000;
            r_wr_valid     <= 1'b0;
            r_sample_taken <= 1'b0;
            r_sda_low      <= 1'b0;
            r_nacked       <= 1'b0;
        end else begin
            r_wr_valid     <= 1'b0;
            r_sample_taken <= 1'b0;
            if (w_stop) begin
                r_sda_low <= 1'b0;
                r_nacked  <= 1'b0;
            end else if (w_start) begin
                r_sda_low   <= 1'b0;
                r_nacked    <= 1'b0;
                r_bit_cnt   <= 4'd0;
                r_ack_phase <= 1'b0;
            end else begin
                case (r_state)
                    S_ADDR: if (w_scl_rise) begin
                        r_shift <= w_shift_next;
                        if (r_bit_cnt == 4'd7) begin
                            r_bit_cnt   <= 4'd0;
                            r_rw        <= w_shift_next[0];
                            r_ack_phase <= 1'b0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end
                    S_ADDR_ACK: if (w_scl_fall) begin
                        if (!r_ack_phase) begin
                            r_ack_phase <= 1'b1;
                            r_sda_low   <= 1'b1;
                            if (r_rw) begin
                                r_tx           <= sample;
                                r_sample_taken <= 1'b1;
                            end
                        end else begin
                            // End of ACK clock: reads present the MSB right away.
                            r_ack_phase <= 1'b0;
                            r_byte_idx  <= 1'b0;
                            r_bit_cnt   <= 4'd0;
                            r_sda_low   <= r_rw ? ~r_tx[15] : 1'b0;
                        end
                    end
                    S_RD_BYTE: begin
                        if (w_scl_rise) r_bit_cnt <= r_bit_cnt + 4'd1;
                        if (w_scl_fall) begin
                            if (r_bit_cnt == 4'd8) r_sda_low <= 1'b0;
                            else                   r_sda_low <= ~w_tx_byte[w_bit_sel];
                        end
                    end
                    S_RD_ACK: if (w_scl_rise) begin
                        r_bit_cnt <= 4'd0;
                        if (!r_sda_s2) r_byte_idx <= ~r_byte_idx;  // wraps 1 -> 0, same word
                        else           r_nacked   <= 1'b1;
                    end
                    S_WR_BYTE: if (w_scl_rise) begin
                        r_shift <= w_shift_next;
                        if (r_bit_cnt == 4'd7) begin
                            r_bit_cnt   <= 4'd0;
                            r_ack_phase <= 1'b0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end
                    S_WR_ACK: if (w_scl_fall) begin
                        if (!r_ack_phase) begin
                            r_ack_phase <= 1'b1;
                            r_sda_low   <= 1'b1;
                        end else begin
                            r_ack_phase <= 1'b0;
                            r_sda_low   <= 1'b0;
                            r_bit_cnt   <= 4'd0;
                            if (!r_byte_idx) begin
                                r_wr_hi    <= r_shift;
                                r_byte_idx <= 1'b1;
                            end else begin
                                r_wr_data  <= {r_wr_hi, r_shift};
                                r_wr_valid <= 1'b1;
                                r_byte_idx <= 1'b0;
                            end
                        end
                    end
                    default: r_sda_low <= 1'b0;
                endcase
            end
        end
    end

    // Outputs
    always_comb begin
        busy = 1'b0;
        case (r_state)
            S_ADDR_ACK, S_RD_BYTE, S_RD_ACK, S_WR_BYTE, S_WR_ACK: busy = 1'b1;
            S_IGNORE: busy = r_nacked;
            default:  busy = 1'b0;
        endcase
    end

    assign sda          = r_sda_low ? 1'b0 : 1'bz;
    assign sample_taken = r_sample_taken;
    assign wr_valid     = r_wr_valid;
    assign wr_data      = r_wr_data;

endmodule
